// File: rtl/id_decode_queue.sv
// RV64I decode stage with a QDEPTH-entry raw-instruction queue between IF and EX.
// Latency 1 cycle IF->ID when the queue is empty and the output slot is free; otherwise 1 + queue occupancy.
// Backpressure: the output bundle holds while !ex_ready; if_ready drops when the queue is full.
// Optional: define ID_PERF_CNT_EN to add perf_issued/perf_stall counters.
module id_decode_queue #(
  parameter int XLEN   = 64,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            rs1_ena,
  output logic            rs2_ena,
  output logic            rd_ena,
  output logic [XLEN-1:0] imm,
  output logic [12:0]     op_info,
  output logic [9:0]      alu_info,
  output logic [7:0]      bj_info,
  output logic            is_word,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [1:0]      mem_size,
  output logic            mem_uns,
  output logic            illegal
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     q_inst [QDEPTH];
  logic [XLEN-1:0] q_pc   [QDEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic q_empty, slot_free, enq, deq, bypass, q_push, load;
  logic [31:0]     d_inst;
  logic [XLEN-1:0] d_pc;

  // if_ready depends only on the count, so a full queue never accepts even while draining
  assign if_ready  = (count != CW'(QDEPTH));
  assign q_empty   = (count == '0);
  assign slot_free = !id_valid || ex_ready;
  assign enq       = if_valid && if_ready && !flush;
  assign deq       = !q_empty && slot_free && !flush;
  assign bypass    = q_empty && slot_free && enq;
  assign q_push    = enq && !bypass;
  assign load      = deq || bypass;
  assign d_inst    = q_empty ? if_inst : q_inst[rd_ptr];
  assign d_pc      = q_empty ? if_pc   : q_pc[rd_ptr];

  // Queue storage: payload only, validity is tracked by count
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_inst[wr_ptr] <= if_inst;
      q_pc[wr_ptr]   <= if_pc;
    end
  end

  // Queue pointers and occupancy; flush empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + 1'b1;
      if (deq)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(q_push) - CW'(deq);
    end
  end

  // ---------------- decode of the selected instruction ----------------
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [12:0] n_op;
  logic        c_load, c_fence, c_arith, c_auipc, c_arithw, c_store, c_r;
  logic        c_lui, c_rw, c_branch, c_jalr, c_jal, c_sys;

  assign opc = d_inst[6:0];
  assign f3  = d_inst[14:12];

  // One-hot opcode class; no bit set means an unsupported opcode
  always_comb begin
    n_op = '0;
    case (opc)
      7'h03:   n_op[0]  = 1'b1;
      7'h0f:   n_op[1]  = 1'b1;
      7'h13:   n_op[2]  = 1'b1;
      7'h17:   n_op[3]  = 1'b1;
      7'h1b:   n_op[4]  = 1'b1;
      7'h23:   n_op[5]  = 1'b1;
      7'h33:   n_op[6]  = 1'b1;
      7'h37:   n_op[7]  = 1'b1;
      7'h3b:   n_op[8]  = 1'b1;
      7'h63:   n_op[9]  = 1'b1;
      7'h67:   n_op[10] = 1'b1;
      7'h6f:   n_op[11] = 1'b1;
      7'h73:   n_op[12] = 1'b1;
      default: n_op = '0;
    endcase
  end

  assign {c_sys, c_jal, c_jalr, c_branch, c_rw, c_lui, c_r, c_store,
          c_arithw, c_auipc, c_arith, c_fence, c_load} = n_op;

  logic [9:0]      n_alu;
  logic [7:0]      n_bj;
  logic [XLEN-1:0] n_imm;
  logic            n_r1e, n_r2e, n_rde;

  // ALU/branch class, immediate format and register enables
  always_comb begin
    n_alu = '0;
    n_bj  = '0;
    n_imm = '0;
    if (c_load | c_store | c_jal | c_jalr | c_lui | c_auipc) n_alu[0] = 1'b1;
    if (c_arith | c_arithw | c_r | c_rw) begin
      case (f3)
        3'd0: if ((c_r | c_rw) & d_inst[30]) n_alu[1] = 1'b1;
              else n_alu[0] = 1'b1;
        3'd1: n_alu[7] = 1'b1;
        3'd2: n_alu[2] = 1'b1;
        3'd3: n_alu[3] = 1'b1;
        3'd4: n_alu[4] = 1'b1;
        3'd5: if (d_inst[30]) n_alu[9] = 1'b1;
              else n_alu[8] = 1'b1;
        3'd6: n_alu[5] = 1'b1;
        3'd7: n_alu[6] = 1'b1;
        default: n_alu = '0;
      endcase
    end
    if (c_branch) begin
      case (f3)
        3'd0: begin n_alu[4] = 1'b1; n_bj[0] = 1'b1; end
        3'd1: begin n_alu[4] = 1'b1; n_bj[1] = 1'b1; end
        3'd4: begin n_alu[2] = 1'b1; n_bj[2] = 1'b1; end
        3'd5: begin n_alu[2] = 1'b1; n_bj[3] = 1'b1; end
        3'd6: begin n_alu[3] = 1'b1; n_bj[4] = 1'b1; end
        3'd7: begin n_alu[3] = 1'b1; n_bj[5] = 1'b1; end
        default: n_bj = '0;
      endcase
    end
    if (c_jalr) n_bj[6] = 1'b1;
    if (c_jal)  n_bj[7] = 1'b1;

    if (c_load | c_fence | c_arith | c_arithw | c_jalr | c_sys)
      n_imm = XLEN'($signed(d_inst[31:20]));
    else if (c_store)
      n_imm = XLEN'($signed({d_inst[31:25], d_inst[11:7]}));
    else if (c_branch)
      n_imm = XLEN'($signed({d_inst[31], d_inst[7], d_inst[30:25], d_inst[11:8], 1'b0}));
    else if (c_lui | c_auipc)
      n_imm = XLEN'($signed({d_inst[31:12], 12'b0}));
    else if (c_jal)
      n_imm = XLEN'($signed({d_inst[31], d_inst[19:12], d_inst[20], d_inst[30:21], 1'b0}));

    n_r1e = c_load | c_fence | c_arith | c_arithw | c_store | c_r | c_rw | c_branch | c_jalr | c_sys;
    n_r2e = c_store | c_r | c_rw | c_branch;
    n_rde = (c_load | c_arith | c_auipc | c_arithw | c_r | c_lui | c_rw | c_jalr | c_jal | c_sys)
            && (d_inst[11:7] != 5'd0);
  end

  // Output register: loads on bypass or dequeue, holds under backpressure, cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      rs1_addr <= '0;
      rs2_addr <= '0;
      rd_addr  <= '0;
      rs1_ena  <= 1'b0;
      rs2_ena  <= 1'b0;
      rd_ena   <= 1'b0;
      imm      <= '0;
      op_info  <= '0;
      alu_info <= '0;
      bj_info  <= '0;
      is_word  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_size <= '0;
      mem_uns  <= 1'b0;
      illegal  <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load) begin
      id_valid <= 1'b1;
      id_pc    <= d_pc;
      rs1_addr <= n_r1e ? d_inst[19:15] : 5'd0;
      rs2_addr <= n_r2e ? d_inst[24:20] : 5'd0;
      rd_addr  <= n_rde ? d_inst[11:7]  : 5'd0;
      rs1_ena  <= n_r1e;
      rs2_ena  <= n_r2e;
      rd_ena   <= n_rde;
      imm      <= n_imm;
      op_info  <= n_op;
      alu_info <= n_alu;
      bj_info  <= n_bj;
      is_word  <= c_arithw | c_rw;
      mem_rd   <= c_load;
      mem_wr   <= c_store;
      mem_size <= (c_load | c_store) ? f3[1:0] : 2'd0;
      mem_uns  <= c_load & f3[2];
      illegal  <= ~|n_op;
    end else if (slot_free) begin
      id_valid <= 1'b0;
    end
  end

`ifdef ID_PERF_CNT_EN
  // Handshake and stall counters; survive flush, wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (id_valid && ex_ready)  perf_issued <= perf_issued + 32'd1;
      if (id_valid && !ex_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
